// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns one at a time, reads the rows, and
// debounces whole-matrix frames into one hex key code per physical press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 125000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  logic [3:0]       row_m_q, row_s_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_code_q;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             down_q, down_d;
  logic             valid_q, valid_d;

  logic       slot_end, frame_end;
  logic [2:0] hits, sum;
  logic [1:0] first_r;
  logic [1:0] frame_cnt;
  logic [3:0] frame_code;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: return 4'h1;
      4'h1: return 4'h4;
      4'h2: return 4'h7;
      4'h3: return 4'h0;
      4'h4: return 4'h2;
      4'h5: return 4'h5;
      4'h6: return 4'h8;
      4'h7: return 4'hF;
      4'h8: return 4'h3;
      4'h9: return 4'h6;
      4'hA: return 4'h9;
      4'hB: return 4'hE;
      4'hC: return 4'hA;
      4'hD: return 4'hB;
      4'hE: return 4'hC;
      default: return 4'hD;
    endcase
  endfunction

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (col_idx_q == 2'd3);

  // Merge the current column sample into the running frame; the descending loop
  // leaves the lowest pressed row in first_r.
  always_comb begin
    hits    = '0;
    first_r = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s_q[r]) begin
        hits    = hits + 3'd1;
        first_r = 2'(r);
      end
    end
    sum        = {1'b0, acc_cnt_q} + hits;
    frame_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frame_code = (acc_cnt_q == 2'd0 && hits != 3'd0) ? key_map(col_idx_q, first_r) : acc_code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m_q    <= 4'b1111;
      row_s_q    <= 4'b1111;
      div_q      <= '0;
      col_idx_q  <= '0;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      row_m_q <= row;
      row_s_q <= row_m_q;
      if (slot_end) begin
        div_q     <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'd3) begin
          acc_cnt_q  <= '0;
          acc_code_q <= '0;
        end else begin
          acc_cnt_q  <= frame_cnt;
          acc_code_q <= frame_code;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      down_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      down_q  <= down_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Debounce runs once per frame; valid_d is only ever set on a frame edge,
  // so key_valid is a single-cycle pulse at most once per frame.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    down_d  = down_q;
    valid_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_cnt == 2'd1) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
            if (CNT_DONE == CNT_W'(1)) begin
              state_d = HELD;
              code_d  = frame_code;
              down_d  = 1'b1;
              valid_d = 1'b1;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (frame_cnt == 2'd1 && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = HELD;
              code_d  = cand_q;
              down_d  = 1'b1;
              valid_d = 1'b1;
            end
          end else if (frame_cnt == 2'd1) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_cnt == 2'd0) begin
            cnt_d = CNT_W'(1);
            if (CNT_DONE == CNT_W'(1)) begin
              state_d = IDLE;
              down_d  = 1'b0;
            end else begin
              state_d = RELEASE_CHK;
            end
          end
        end
        default: begin
          if (frame_cnt == 2'd0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = IDLE;
              down_d  = 1'b0;
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix driven frame by frame,
// checked every cycle against a run-length model of the debounce rules.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DS = 3;
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                                       4'h2, 4'h5, 4'h8, 4'hF,
                                       4'h3, 4'h6, 4'h9, 4'hE,
                                       4'hA, 4'hB, 4'hC, 4'hD};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_down;
  logic [15:0] keys = '0;  // bit c*4+r set = key at (column c, row r) held

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  int n_vec = 0;
  int n_err = 0;

  bit         m_down;
  bit         m_valid;
  logic [3:0] m_code;
  logic [3:0] last_k;
  int         one_run, none_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_down = 0; m_valid = 0; m_code = 4'h0; last_k = 4'h0;
    one_run = 0; none_run = 0;
  endtask

  // A press is accepted when DS consecutive frames show the same single key while
  // not held; a release when DS consecutive empty frames follow while held.
  task automatic model_frame(input logic [15:0] m);
    int n = $countones(m);
    int k = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    m_valid = 0;
    if (n == 1) begin
      if (one_run > 0 && last_k == KMAP[k]) one_run++;
      else begin one_run = 1; last_k = KMAP[k]; end
    end else one_run = 0;
    if (n == 0) none_run++; else none_run = 0;
    if (!m_down && one_run == DS) begin
      m_down = 1; m_code = last_k; m_valid = 1;
    end else if (m_down && none_run == DS) m_down = 0;
  endtask

  task automatic run_frame(input logic [15:0] m);
    logic [3:0] e;
    keys = m;
    for (int i = 0; i < 16; i++) begin
      e = 4'hF;
      e[i/4] = 1'b0;
      check("col", 32'(col), 32'(e));
      check("key_valid", 32'(key_valid), 32'((i == 0) && m_valid));
      check("key_down", 32'(key_down), 32'(m_down));
      if (i == 0) check("key_code", 32'(key_code), 32'(m_code));
      @(negedge clk);
    end
    model_frame(m);
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic reset_mid(input logic [15:0] m, input int ncyc);
    keys = m;
    repeat (ncyc) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_col", 32'(col), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [15:0] K5 = 16'h0020;  // c1 r1
  localparam logic [15:0] KA = 16'h1000;  // c3 r0
  localparam logic [15:0] K1 = 16'h0001;  // c0 r0
  localparam logic [15:0] K9 = 16'h0400;  // c2 r2

  initial begin
    model_reset();
    @(negedge clk);
    check("init_col", 32'(col), 32'hE);
    check("init_valid", 32'(key_valid), 32'h0);
    check("init_down", 32'(key_down), 32'h0);
    check("init_code", 32'(key_code), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_frames(16'h0, 2);
    run_frames(K5, 5);
    run_frames(16'h0, 5);
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? KA : 16'h0);
    run_frames(KA, 5);
    run_frames(16'h0, 5);
    run_frames(K1 | K9, 4);
    run_frames(K1, 4);
    run_frames(K1 | K9, 3);
    run_frames(16'h0, 5);
    run_frames(K5, 2);
    reset_mid(K5, 5);
    run_frames(K5, 4);
    run_frames(16'h0, 4);

    for (int s = 0; s < 40; s++) begin
      logic [15:0] m;
      int a, b;
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0: m = 16'h0;
        1, 2: m = 16'(1) << a;
        default: m = (16'(1) << a) | (16'(1) << b);
      endcase
      run_frames(m, $urandom_range(1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment driver. The display driver time-multiplexes outputs by strobing digit anodes; this block time-multiplexes inputs by strobing the columns of a 4x4 matrix keypad and reading the rows.
- Debounces the result and emits one hex key code per physical press.
- Sits between the keypad header pins and user logic, for example to feed digits into segment_driver.

Parameters:
- SCAN_DIV, 125000, clock cycles each column is driven (1 ms at 125 MHz); minimum 4.
- DEBOUNCE_SCANS, 5, number of consecutive identical full-matrix frames needed to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
- col  output 4  keypad column drive, active-low one-hot
- key_code  output 4  hex value of the last accepted key
- key_valid  output 1  single-cycle pulse when a new key is accepted
- key_down  output 1  high while the accepted key is held (debounced)

Behaviour:
- Reset values (asynchronous): col=4'b1110, key_code=4'h0, key_valid=0, key_down=0, state IDLE. All counters and the frame accumulator are cleared. Synchroniser flops are set to 4'b1111.
- row passes through a 2-flop synchroniser (row_s) before any use.
- Column scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps. The active column index c (0..3) advances when div_cnt wraps.
  - col = ~(1<<c). Columns 3 to 0 wrap.
  - row_s is sampled on the edge where div_cnt==SCAN_DIV-1, the last cycle of the slot, which gives settling time.
- Key map, (column,row) -> code:
  - c0: r0..r3 = 1,4,7,0
  - c1: r0..r3 = 2,5,8,F
  - c2: r0..r3 = 3,6,9,E
  - c3: r0..r3 = A,B,C,D
- Frame:
  - Four column samples, c0..c3, make one frame.
  - The accumulator counts pressed bits (row_s==0) in the frame, saturating at 2, and stores the code of the first pressed bit found: lowest column, then lowest row.
  - At the column-3 sample edge, the frame is classified as NONE (0 pressed), ONE(k), or MULTI (2 or more). The FSM updates on that same edge and the accumulator clears.
- Debounce FSM, with cand (4-bit) and cnt (counts to DEBOUNCE_SCANS):
  - IDLE:
    - ONE(k) -> PRESS_CHK, cand=k, cnt=1; if DEBOUNCE_SCANS==1, accept immediately.
    - NONE or MULTI -> stay.
  - PRESS_CHK:
    - ONE(cand) -> cnt++; when cnt reaches DEBOUNCE_SCANS -> HELD, key_code=cand, key_down=1, key_valid=1 for exactly the next cycle.
    - ONE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> RELEASE_CHK, cnt=1; if DEBOUNCE_SCANS==1, go to IDLE at once.
    - ONE(any) or MULTI -> stay. There is no auto-repeat, and a different key is ignored until release.
  - RELEASE_CHK:
    - NONE -> cnt++; at DEBOUNCE_SCANS -> IDLE, key_down=0.
    - ONE or MULTI -> HELD, with no new key_valid.
- key_code holds its value until the next accepted press; it is not cleared on release.
- key_valid never asserts on two consecutive cycles. At most one key_valid per frame.
- Reset asserted mid-scan or mid-debounce returns all state to reset values asynchronously. The scan restarts at column 0, slot start, after deassertion.

Test Plan:
- Reset/scan: SCAN_DIV=4, no keys -> col after reset is 1110, then 1101, 1011, 0111, 1110, each held exactly 4 cycles; key_valid=0, key_down=0 throughout.
- Single press: SCAN_DIV=4, DEBOUNCE_SCANS=3, hold key '5' (row1 low only while col1 is driven) from reset release -> exactly one key_valid pulse at the end of frame 3 (cycle 48±2), key_code=4'h5, key_down=1 until release.
- Release debounce: after the press above, release -> key_down drops exactly 3 frames after the first all-high frame; key_code stays 5; no extra key_valid.
- Bounce: toggle key 'A' (c3,r0) pressed/released on alternate frames for 10 frames, then hold -> no key_valid during the toggling; one key_valid with key_code=4'hA after 3 stable frames.
- Multi-key: press '1' and '9' together from IDLE -> no key_valid, no key_down. During HELD of '1', add '9' -> key_down stays 1, no new key_valid.
- Reset mid-debounce: assert rst during PRESS_CHK cnt=2 -> outputs return to reset values immediately; after deassertion, the key needs the full 3 frames again before key_valid.
